spi_instr_frontend: RTL
=======================

SPI_INSTR_FRONTEND -- requirements
Module: spi_instr_frontend

Interface
REQ-001 Parameter OPCODE_WIDTH, default 4: width of the opcode field in a frame.
REQ-002 Parameter OPERAND_WIDTH, default 8: width of the operand field in a frame.
REQ-003 Parameter RESULT_WIDTH, default 8: width of the result byte returned on MISO.
REQ-004 Parameter SYNC_STAGES, default 2: number of synchroniser flops on each SPI input.
REQ-005 Port clk, input, 1: the only clock; all logic SHALL be on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port spi_sclk, input, 1: SPI serial clock, asynchronous to clk, mode 0.
REQ-008 Port spi_cs_n, input, 1: SPI chip select, active low, asynchronous to clk.
REQ-009 Port spi_mosi, input, 1: SPI serial data in, MSB first.
REQ-010 Port spi_miso, output, 1: SPI serial data out, MSB first.
REQ-011 Port result, input, RESULT_WIDTH: CPU output byte to return to the host.
REQ-012 Port opcode, output, OPCODE_WIDTH: last accepted opcode, held until the next accepted frame.
REQ-013 Port operand, output, OPERAND_WIDTH: last accepted operand, held until the next accepted frame.
REQ-014 Port start, output, 1: one-clk pulse marking a newly accepted instruction.
REQ-015 Port frame_err, output, 1: one-clk pulse marking a discarded frame.

Function
REQ-016 Synchronisation: spi_sclk, spi_cs_n and spi_mosi SHALL pass through SYNC_STAGES flops, then through one edge-detect flop.
REQ-017 Frame layout: FRAME_LEN = OPCODE_WIDTH + OPERAND_WIDTH bits (12 by default), opcode first, each field MSB first.
REQ-018 Sampling: MOSI SHALL be sampled on each synchronised sclk rising edge while cs_n is low.
REQ-019 FSM states: IDLE, RECV, HOLD.
- IDLE -> RECV on cs_n falling edge; bit counter cleared.
- RECV -> HOLD when the bit counter reaches FRAME_LEN.
- RECV -> IDLE on cs_n rising edge.
- HOLD -> IDLE on cs_n rising edge.
REQ-020 Accept: on entry to HOLD, opcode and operand SHALL update together and start SHALL pulse high for exactly one clk.
- Timing: the pulse falls in clk cycle SYNC_STAGES+2 after the final sclk rising edge at the pin, ±1 cycle for synchroniser phase.
REQ-021 Short frame: cs_n rising in RECV with 1..FRAME_LEN-1 bits received SHALL pulse frame_err for one clk.
- opcode, operand and start SHALL be unchanged.
REQ-022 Empty frame: cs_n rising in RECV with 0 bits received SHALL be ignored silently.
REQ-023 Long frame: sclk edges in HOLD SHALL be ignored.
- The accepted instruction SHALL NOT be altered.
- A single frame_err pulse SHALL be issued on the first extra edge.
REQ-024 MISO: on cs_n falling edge, the TX shift register SHALL load result.
- spi_miso SHALL present the MSB immediately.
- The register SHALL shift on each synchronised sclk falling edge.
- After RESULT_WIDTH bits, spi_miso SHALL drive 0.
REQ-025 spi_miso SHALL drive 0 whenever cs_n is high.
REQ-026 result SHALL be sampled only at load, so changes mid-frame do not affect the bits in flight.
REQ-027 sclk edges while cs_n is high SHALL have no effect.

Reset
REQ-028 rst_n low SHALL asynchronously force:
- FSM to IDLE
- opcode = 0, operand = 0
- start = 0, frame_err = 0, spi_miso = 0
- all synchroniser, shift and counter flops = 0
REQ-029 Synchroniser flops for spi_cs_n SHALL reset to 1 so that release does not create a false cs_n falling edge.
REQ-030 Reset asserted mid-frame SHALL discard the frame with no start and no frame_err.

Configuration
REQ-031 Macro SPI_INSTR_FRONTEND_PARITY_EN:
- When defined, FRAME_LEN gains one trailing odd-parity bit covering opcode and operand.
- With that macro defined, a parity mismatch in HOLD entry SHALL produce frame_err instead of start, with outputs unchanged.
- When undefined, frames are OPCODE_WIDTH + OPERAND_WIDTH bits with no check.

Structure
REQ-032 A shared package SHALL hold:
- the FSM state typedef
- the FRAME_LEN derivation
- default field widths, shared with the execution unit
REQ-033 One sub-module, spi_sync_edge, SHALL contain the synchroniser plus rise/fall edge detect.
- It SHALL be instantiated once each for sclk and cs_n.
- MOSI SHALL use the synchroniser only.

Verification
REQ-034 Send frame 0x3_A5 with result=0xC6 -> opcode=0x3, operand=0xA5, one start pulse; MISO bits read 1,1,0,0,0,1,1,0 then 0,0,0,0.
REQ-035 Raise cs_n after 7 bits -> frame_err pulse; opcode and operand keep their previous values; no start.
REQ-036 Send 14 clocks with frame 0xF_FF, extra bits 1,1 -> one start, opcode=0xF, operand=0xFF, one frame_err.
REQ-037 Assert rst_n low after 6 bits, release, then send frame 0x1_01 -> no pulse before the frame; after it opcode=0x1, operand=0x01, one start.
REQ-038 With PARITY_EN defined, send 0x2_10 with parity 0 -> frame_err; resend with parity 1 -> start, operand=0x10.
REQ-039 Two back-to-back frames 0x4_11, 0x5_22 with cs_n high for 2 sclk periods -> two start pulses, final opcode=0x5, operand=0x22.

Source files
------------

// File: rtl/spi_instr_frontend_pkg.sv
// -----------------------------------------------------------------------------
// spi_instr_frontend_pkg
// Shared definitions for the SPI instruction front end and the execution unit
// that consumes its opcode/operand/start outputs.
//   - default field widths (opcode, operand, result byte)
//   - FSM state type for the frame receiver
//   - frame_len(): number of SPI bits in one instruction frame
// Configuration macro: SPI_INSTR_FRONTEND_PARITY_EN adds one trailing
// odd-parity bit to every frame.
// -----------------------------------------------------------------------------
package spi_instr_frontend_pkg;

    localparam int DEF_OPCODE_WIDTH  = 4;
    localparam int DEF_OPERAND_WIDTH = 8;
    localparam int DEF_RESULT_WIDTH  = 8;

`ifdef SPI_INSTR_FRONTEND_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Frame is opcode then operand (each MSB first), plus optional parity bit.
    function automatic int frame_len(input int opcode_w, input int operand_w);
        return opcode_w + operand_w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk domain through SYNC_STAGES
// flops, followed by one history flop used to detect rising/falling edges.
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   async_i         : raw pin (asynchronous to clk)
//   rise_o, fall_o  : one-clk strobes on a synchronised 0->1 / 1->0 transition
// RESET_VAL sets the idle level the chain resets to, so that a pin sitting at
// that level after reset release produces no spurious edge.
// -----------------------------------------------------------------------------
module spi_sync_edge
    import spi_instr_frontend_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_instr_frontend.sv
// -----------------------------------------------------------------------------
// spi_instr_frontend
// SPI (mode 0) slave that receives one instruction frame per chip-select
// window and returns a result byte on MISO.
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   spi_sclk, spi_cs_n,
//   spi_mosi            : SPI pins, asynchronous to clk
//   spi_miso            : SPI data out, MSB first, 0 when deselected
//   result              : byte loaded into the TX shifter at cs_n fall
//   opcode, operand     : last accepted instruction (held)
//   start               : one-clk pulse when a new instruction is accepted
//   frame_err           : one-clk pulse for a short, long or bad-parity frame
// Configuration macro: SPI_INSTR_FRONTEND_PARITY_EN appends an odd-parity bit
// covering opcode and operand; a mismatch gives frame_err instead of start.
// -----------------------------------------------------------------------------
module spi_instr_frontend
    import spi_instr_frontend_pkg::*;
#(
    parameter int OPCODE_WIDTH  = DEF_OPCODE_WIDTH,
    parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
    parameter int RESULT_WIDTH  = DEF_RESULT_WIDTH,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_sclk,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    input  logic [RESULT_WIDTH-1:0]  result,
    output logic [OPCODE_WIDTH-1:0]  opcode,
    output logic [OPERAND_WIDTH-1:0] operand,
    output logic                     start,
    output logic                     frame_err
);

    localparam int               FRAME_LEN = frame_len(OPCODE_WIDTH, OPERAND_WIDTH);
    localparam int               CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(spi_sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // cs_n idles high: resetting its chain to 1 avoids a false select at release.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(spi_cs_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // MOSI needs no edge detect; its depth matches the sclk chain so the
    // sample lines up with the detected sclk rising edge.
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [FRAME_LEN-2:0]    frame_q;
    logic [FRAME_LEN-1:0]    frame_d;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [OPERAND_WIDTH-1:0] operand_q;
    logic                    start_q, frame_err_q;
    logic                    extra_seen_q;
    logic [RESULT_WIDTH-1:0] tx_q;

    logic cnt_clr, shift_en, hold_entry, short_err, long_err;
    logic parity_ok, accept, parity_err;

    // The final bit goes straight from MOSI into the decode, so the frame
    // register only needs to hold the earlier FRAME_LEN-1 bits.
    assign frame_d = {frame_q, mosi_s};

`ifdef SPI_INSTR_FRONTEND_PARITY_EN
    assign parity_ok = ^frame_d;
`else
    assign parity_ok = 1'b1;
`endif

    assign accept     = hold_entry &  parity_ok;
    assign parity_err = hold_entry & ~parity_ok;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cs_fall) state_d = RECV;
            end
            RECV: begin
                if (cs_rise)                                  state_d = IDLE;
                else if (sclk_rise && (bit_cnt_q == LAST_BIT)) state_d = HOLD;
            end
            HOLD: begin
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: per-cycle control strobes for the datapath below
    always_comb begin
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        hold_entry = 1'b0;
        short_err  = 1'b0;
        long_err   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = cs_fall;
            end
            RECV: begin
                if (cs_rise) begin
                    // A select with no clocks at all is not an error.
                    short_err = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    shift_en   = 1'b1;
                    hold_entry = (bit_cnt_q == LAST_BIT);
                end
            end
            HOLD: begin
                long_err = sclk_rise & ~cs_rise & ~extra_seen_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= '0;
            frame_q      <= '0;
            opcode_q     <= '0;
            operand_q    <= '0;
            start_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            extra_seen_q <= 1'b0;
            tx_q         <= '0;
        end else begin
            if (cnt_clr)       bit_cnt_q <= '0;
            else if (shift_en) bit_cnt_q <= bit_cnt_q + 1'b1;

            if (shift_en) frame_q <= frame_d[FRAME_LEN-2:0];

            if (accept) begin
                opcode_q  <= frame_d[FRAME_LEN-1 -: OPCODE_WIDTH];
                operand_q <= frame_d[FRAME_LEN-1-OPCODE_WIDTH -: OPERAND_WIDTH];
            end

            start_q     <= accept;
            frame_err_q <= short_err | long_err | parity_err;

            // Only the first surplus edge of a long frame is reported.
            if (hold_entry)    extra_seen_q <= 1'b0;
            else if (long_err) extra_seen_q <= 1'b1;

            // result is captured once per frame; zeros shift in behind it so
            // MISO reads 0 after RESULT_WIDTH bits.
            if (cs_fall)                            tx_q <= result;
            else if (sclk_fall && state_q != IDLE)  tx_q <= tx_q << 1;
        end
    end

    // Not IDLE is exactly "synchronised cs_n low", so MISO is 0 when deselected.
    assign spi_miso  = (state_q != IDLE) & tx_q[RESULT_WIDTH-1];
    assign opcode    = opcode_q;
    assign operand   = operand_q;
    assign start     = start_q;
    assign frame_err = frame_err_q;

endmodule
